// File: rtl/osd_text_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : osd_text_writer_if
// Brief   : Character/cursor/hex request bus and char-RAM write port of the
//           OSD text writer.
// Revision: 1.0
// ============================================================================
interface osd_text_writer_if;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  ch_data;
    logic        pos_set;
    logic [5:0]  pos_col;
    logic [4:0]  pos_row;
    logic        hex_valid;
    logic        hex_ready;
    logic [31:0] hex_value;
    logic [3:0]  hex_digits;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    modport master (
        output ch_valid, ch_data, pos_set, pos_col, pos_row,
               hex_valid, hex_value, hex_digits,
        input  ch_ready, hex_ready, wr_addr, wr_data, wr_en, busy, cur_col, cur_row
    );

    modport slave (
        input  ch_valid, ch_data, pos_set, pos_col, pos_row,
               hex_valid, hex_value, hex_digits,
        output ch_ready, hex_ready, wr_addr, wr_data, wr_en, busy, cur_col, cur_row
    );
endinterface
`default_nettype wire

// File: rtl/osd_text_writer.sv
`default_nettype none
// ============================================================================
// Module  : osd_text_writer
// Brief   : Char-RAM write producer: text cursor, control codes, RAM clear and
//           hex printing (hex path built only when OSD_HEX_PRINT_EN is defined).
// Revision: 1.0
// ============================================================================
module osd_text_writer #(
    parameter int         COLS           = 40,
    parameter int         ROWS           = 30,
    parameter int         CHAR_RAM_SIZE  = COLS * ROWS,
    parameter logic [7:0] CLEAR_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input wire clk,
    input wire reset,
    osd_text_writer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_HEX   = 2'd2
    } state_t;

    localparam logic [5:0]  c_COL_MAX  = 6'(COLS - 1);
    localparam logic [4:0]  c_ROW_MAX  = 5'(ROWS - 1);
    localparam logic [10:0] c_COLS     = 11'(COLS);
    localparam logic [10:0] c_CLR_LAST = 11'(CHAR_RAM_SIZE - 1);

    state_t      r_state, w_state_nxt;
    logic        r_idle;
    logic        r_busy;
    logic        r_wr_en, w_wr_en_nxt;
    logic [10:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]  r_wr_data, w_wr_data_nxt;
    logic [5:0]  r_col, w_col_nxt;
    logic [4:0]  r_row, w_row_nxt;
    logic [10:0] r_clr_addr, w_clr_addr_nxt;

    logic        w_ch_ready, w_hex_ready, w_ch_fire, w_hex_fire;
    logic        w_col_last;
    logic [4:0]  w_row_inc, w_adv_row;
    logic [5:0]  w_adv_col;
    logic [10:0] w_cur_addr;

    // Readiness is a registered idle flag, gated by same-cycle higher-priority inputs.
    assign w_ch_ready  = r_idle && !bus.pos_set;
    assign w_hex_ready = r_idle && !bus.pos_set && !bus.ch_valid;
    assign w_ch_fire   = bus.ch_valid && w_ch_ready;
    assign w_hex_fire  = bus.hex_valid && w_hex_ready;

    assign w_col_last = (r_col == c_COL_MAX);
    assign w_row_inc  = (r_row == c_ROW_MAX) ? 5'd0 : r_row + 5'd1;
    assign w_adv_col  = w_col_last ? 6'd0 : r_col + 6'd1;
    assign w_adv_row  = w_col_last ? w_row_inc : r_row;
    assign w_cur_addr = 11'(r_row) * c_COLS + 11'(r_col);

`ifdef OSD_HEX_PRINT_EN
    logic [31:0] r_hex_sh, w_hex_sh_nxt;
    logic [3:0]  r_hex_cnt, w_hex_cnt_nxt;
    logic [3:0]  w_hex_n;
    logic [5:0]  w_hex_shamt;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_hex_n     = (bus.hex_digits == 4'd0 || bus.hex_digits > 4'd8) ? 4'd8 : bus.hex_digits;
    // Left-align the printed digits so each step emits the top nibble.
    assign w_hex_shamt = {4'd8 - w_hex_n, 2'b00};
`else
    logic w_unused_hex;
    assign w_unused_hex = ^{bus.hex_value, bus.hex_digits};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_clr_addr_nxt = r_clr_addr;
`ifdef OSD_HEX_PRINT_EN
        w_hex_sh_nxt   = r_hex_sh;
        w_hex_cnt_nxt  = r_hex_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.pos_set) begin
                    w_col_nxt = (bus.pos_col > c_COL_MAX) ? c_COL_MAX : bus.pos_col;
                    w_row_nxt = (bus.pos_row > c_ROW_MAX) ? c_ROW_MAX : bus.pos_row;
                end else if (w_ch_fire) begin
                    case (bus.ch_data)
                        8'h0D: w_col_nxt = 6'd0;
                        8'h0A: begin
                            w_col_nxt = 6'd0;
                            w_row_nxt = w_row_inc;
                        end
                        8'h0C: begin
                            w_state_nxt    = S_CLEAR;
                            w_col_nxt      = 6'd0;
                            w_row_nxt      = 5'd0;
                            w_clr_addr_nxt = 11'd0;
                        end
                        default: begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = w_cur_addr;
                            w_wr_data_nxt = bus.ch_data;
                            w_col_nxt     = w_adv_col;
                            w_row_nxt     = w_adv_row;
                        end
                    endcase
                end else if (w_hex_fire) begin
`ifdef OSD_HEX_PRINT_EN
                    w_state_nxt   = S_HEX;
                    w_hex_sh_nxt  = bus.hex_value << w_hex_shamt;
                    w_hex_cnt_nxt = w_hex_n;
`endif
                end
            end
            S_CLEAR: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_clr_addr;
                w_wr_data_nxt = CLEAR_CHAR;
                if (r_clr_addr == c_CLR_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_addr_nxt = 11'd0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 11'd1;
                end
            end
`ifdef OSD_HEX_PRINT_EN
            S_HEX: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = w_cur_addr;
                w_wr_data_nxt = hex_ascii(r_hex_sh[31:28]);
                w_hex_sh_nxt  = {r_hex_sh[27:0], 4'h0};
                w_hex_cnt_nxt = r_hex_cnt - 4'd1;
                w_col_nxt     = w_adv_col;
                w_row_nxt     = w_adv_row;
                if (r_hex_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle     <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 11'd0;
            r_wr_data  <= 8'd0;
            r_col      <= 6'd0;
            r_row      <= 5'd0;
            r_clr_addr <= 11'd0;
`ifdef OSD_HEX_PRINT_EN
            r_hex_sh   <= 32'd0;
            r_hex_cnt  <= 4'd0;
`endif
        end else begin
            // busy marks the cycles carrying clear/hex writes; ready waits until they end.
            r_idle     <= (w_state_nxt == S_IDLE) && (r_state == S_IDLE);
            r_busy     <= (r_state != S_IDLE);
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_clr_addr <= w_clr_addr_nxt;
`ifdef OSD_HEX_PRINT_EN
            r_hex_sh   <= w_hex_sh_nxt;
            r_hex_cnt  <= w_hex_cnt_nxt;
`endif
        end
    end

    assign bus.ch_ready  = w_ch_ready;
    assign bus.hex_ready = w_hex_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.cur_col   = r_col;
    assign bus.cur_row   = r_row;

endmodule
`default_nettype wire
